// File: rtl/dadda_pkg.sv
// Shared sizing constants for the 16x16 Dadda multiplier datapath.
// The reduction tree and the final carry-propagate adder both pull their
// widths from here so the two halves can never disagree on row size.
package dadda_pkg;

   localparam int MUL_W     = 16;
   localparam int PROD_W    = 2 * MUL_W;
   localparam int CPA_SPLIT = 16;

endpackage

// File: rtl/fa.sv
// Single-bit full adder cell used as the building block of the ripple slices.
module fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   // Sum and carry-out of one bit position.
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/rca_slice.sv
// N-bit ripple-carry adder slice built from a chain of fa cells.
// The final adder uses two of these so that each register-to-register path
// holds only one slice worth of carry ripple.
module rca_slice #(
   parameter int N = 16
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         ci,
   output logic [N-1:0] s,
   output logic         co
);

   logic [N:0] w_carry;

   assign w_carry[0] = ci;

   // One full adder per bit, carry rippling from bit 0 upwards.
   for (genvar i = 0; i < N; i++) begin : g_bit
      fa u_fa (
         .a  (a[i]),
         .b  (b[i]),
         .ci (w_carry[i]),
         .s  (s[i]),
         .co (w_carry[i+1])
      );
   end

   assign co = w_carry[N];

endmodule

// File: rtl/dadda_final_cpa.sv
// Two-stage pipelined final carry-propagate adder for the Dadda multiplier.
// Stage 1 adds the low SPLIT bits and parks the high halves plus the carry;
// stage 2 finishes the high half and presents the wrapped product.
// Valid/ready on both sides lets the datapath stall without losing pairs.
module dadda_final_cpa
   import dadda_pkg::*;
#(
   parameter int WIDTH = PROD_W,
   parameter int SPLIT = CPA_SPLIT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] row_a,
   input  logic [WIDTH-1:0] row_b,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] prod,
   output logic             out_valid,
   input  logic             out_ready
);

   localparam int HI_W = WIDTH - SPLIT;

   logic [SPLIT-1:0] r_loSum;
   logic             r_c1;
   logic [HI_W-1:0]  r_hiA;
   logic [HI_W-1:0]  r_hiB;
   logic             r_s1Valid;
   logic [WIDTH-1:0] r_prod;
   logic             r_outValid;

   logic [SPLIT-1:0] w_loSum;
   logic             w_loCarry;
   logic [HI_W-1:0]  w_hiSum;
   logic             w_unusedCarry;
   logic             w_s2Accept;
   logic             w_s1Accept;
   logic             w_inXfer;
   logic             w_move;

   // Low half of the addition, evaluated straight off the input rows.
   rca_slice #(.N(SPLIT)) u_loSlice (
      .a  (row_a[SPLIT-1:0]),
      .b  (row_b[SPLIT-1:0]),
      .ci (1'b0),
      .s  (w_loSum),
      .co (w_loCarry)
   );

   // High half, fed from the stage 1 registers; the top carry wraps away.
   rca_slice #(.N(HI_W)) u_hiSlice (
      .a  (r_hiA),
      .b  (r_hiB),
      .ci (r_c1),
      .s  (w_hiSum),
      .co (w_unusedCarry)
   );

   // Ready chain: a stage can take data if it is empty or is emptying now.
   assign w_s2Accept = !r_outValid || out_ready;
   assign w_s1Accept = !r_s1Valid || w_s2Accept;
   assign w_inXfer   = in_valid && w_s1Accept;
   assign w_move     = r_s1Valid && w_s2Accept;

   assign in_ready   = w_s1Accept;
   assign prod       = r_prod;
   assign out_valid  = r_outValid;

   // Stage 1: capture the low sum, its carry and the untouched high halves.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1Valid <= 1'b0;
         r_loSum   <= '0;
         r_c1      <= 1'b0;
         r_hiA     <= '0;
         r_hiB     <= '0;
      end else if (w_inXfer) begin
         r_s1Valid <= 1'b1;
         r_loSum   <= w_loSum;
         r_c1      <= w_loCarry;
         r_hiA     <= row_a[WIDTH-1:SPLIT];
         r_hiB     <= row_b[WIDTH-1:SPLIT];
      end else if (w_move) begin
         r_s1Valid <= 1'b0;
      end
   end

   // Stage 2: assemble the product when stage 1 hands over, else drain.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_outValid <= 1'b0;
         r_prod     <= '0;
      end else if (w_move) begin
         r_outValid <= 1'b1;
         r_prod     <= {w_hiSum, r_loSum};
      end else if (r_outValid && out_ready) begin
         r_outValid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dadda_final_cpa.sv
// Self-checking bench for dadda_final_cpa: a monitor scoreboards every
// output transfer against a plain-arithmetic sum, while the main sequence
// adds directed timing, backpressure and reset checks.
module tb_dadda_final_cpa;

   logic        clk;
   logic        rst;
   logic [31:0] row_a;
   logic [31:0] row_b;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] prod;
   logic        out_valid;
   logic        out_ready;

   int          nCompared;
   int          nMismatched;
   int          nResults;
   logic [31:0] expQ[$];

   dadda_final_cpa dut (
      .clk       (clk),
      .rst       (rst),
      .row_a     (row_a),
      .row_b     (row_b),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .prod      (prod),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something wedges beyond every local bound.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // Reference: the product row is simply the two rows added, wrapped at 32 bits.
   function automatic logic [31:0] refSum(input logic [31:0] a, input logic [31:0] b);
      longint unsigned s;
      s = longint'(a) + longint'(b);
      return 32'(s % 64'h1_0000_0000);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] required);
      nCompared++;
      if (actual !== required) begin
         nMismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, required);
      end
   endtask

   // Scoreboard monitor: pops on output transfers, pushes on input transfers.
   always @(negedge clk) begin
      if (rst) begin
         expQ.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               nCompared++;
               nMismatched++;
               $display("[TB] FAIL unexpected output: got 0x%08h, expected no output", prod);
            end else begin
               checkOutput("scoreboard prod", prod, expQ.pop_front());
               nResults++;
            end
         end
         if (in_valid && in_ready)
            expQ.push_back(refSum(row_a, row_b));
      end
   end

   // Present a pair and hold it until the block signals ready.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, output int waits);
      @(posedge clk);
      #1;
      row_a    = a;
      row_b    = b;
      in_valid = 1'b1;
      waits    = 0;
      @(negedge clk);
      while (!in_ready && waits < 50) begin
         waits++;
         @(negedge clk);
      end
      if (!in_ready) begin
         nCompared++;
         nMismatched++;
         $display("[TB] FAIL accept timeout: got in_ready=0, expected 1 within 50 cycles");
      end
   endtask

   // Single isolated pair: checks exact two-cycle latency and a known product.
   task automatic directedPair(input string name, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] expConst);
      int w;
      applyStimulus(a, b, w);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      checkOutput({name, " out_valid early"}, 32'(out_valid), 32'd0);
      @(negedge clk);
      checkOutput({name, " out_valid"}, 32'(out_valid), 32'd1);
      checkOutput({name, " prod"}, prod, expConst);
   endtask

   // Wait for the pipeline and scoreboard to empty with out_ready held high.
   task automatic waitDrain();
      int n;
      n = 0;
      while ((expQ.size() != 0 || out_valid) && n < 50) begin
         @(negedge clk);
         n++;
      end
      checkOutput("drain complete", 32'(expQ.size()), 32'd0);
   endtask

   initial begin
      int          w;
      int          startResults;
      logic [31:0] p1a, p1b, p2a, p2b, p3a, p3b;

      nCompared   = 0;
      nMismatched = 0;
      nResults    = 0;
      rst         = 1'b1;
      in_valid    = 1'b1;
      row_a       = 32'h1234_5678;
      row_b       = 32'h0F0F_0F0F;
      out_ready   = 1'b1;

      repeat (2) begin
         @(negedge clk);
         checkOutput("reset in_ready", 32'(in_ready), 32'd1);
         checkOutput("reset out_valid", 32'(out_valid), 32'd0);
         checkOutput("reset prod", prod, 32'd0);
      end
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;

      directedPair("split carry", 32'h0000_8000, 32'h0000_8000, 32'h0001_0000);
      directedPair("full chain", 32'hFFFF_0001, 32'h0000_FFFF, 32'h0000_0000);
      directedPair("max product", 32'hFFFE_0000, 32'h0000_0001, 32'hFFFE_0001);
      waitDrain();

      startResults = nResults;
      for (int i = 0; i < 100; i++) begin
         applyStimulus($urandom, $urandom, w);
         checkOutput("stream in_ready stall", 32'(w), 32'd0);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      waitDrain();
      checkOutput("stream result count", 32'(nResults - startResults), 32'd100);

      p1a = $urandom; p1b = $urandom;
      p2a = $urandom; p2b = $urandom;
      p3a = $urandom; p3b = $urandom;
      startResults = nResults;
      @(posedge clk);
      #1 out_ready = 1'b0;
      applyStimulus(p1a, p1b, w);
      checkOutput("bp first accept", 32'(w), 32'd0);
      applyStimulus(p2a, p2b, w);
      checkOutput("bp second accept", 32'(w), 32'd0);
      @(posedge clk);
      #1;
      row_a = p3a;
      row_b = p3b;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checkOutput("bp in_ready low", 32'(in_ready), 32'd0);
         checkOutput("bp out_valid held", 32'(out_valid), 32'd1);
         checkOutput("bp prod held", prod, refSum(p1a, p1b));
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp release in_ready", 32'(in_ready), 32'd1);
      checkOutput("bp drain 1 valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      checkOutput("bp drain 2 valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      checkOutput("bp drain 3 valid", 32'(out_valid), 32'd1);
      @(negedge clk);
      checkOutput("bp drain empty", 32'(out_valid), 32'd0);
      checkOutput("bp result count", 32'(nResults - startResults), 32'd3);

      @(posedge clk);
      #1 out_ready = 1'b0;
      applyStimulus($urandom, $urandom, w);
      applyStimulus($urandom, $urandom, w);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      checkOutput("pre-reset in_ready", 32'(in_ready), 32'd0);
      checkOutput("pre-reset out_valid", 32'(out_valid), 32'd1);
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("mid reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("mid reset prod", prod, 32'd0);
      checkOutput("mid reset in_ready", 32'(in_ready), 32'd1);
      repeat (3) begin
         @(negedge clk);
         checkOutput("post reset no replay", 32'(out_valid), 32'd0);
      end
      startResults = nResults;
      applyStimulus($urandom, $urandom, w);
      @(posedge clk);
      #1 in_valid = 1'b0;
      waitDrain();
      checkOutput("post reset result count", 32'(nResults - startResults), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
